timer_apb_regif: RTL and testbench
==================================

Name: timer_apb_regif

Overview:
- APB responder (slave) for the timer register file. It completes CPU-side read and write transfers on an 8-bit address/data bus, with a configurable number of wait states and an error response.
- Holds the TDR, TCR and TSR registers. Drives the control fields to the counter core. Captures overflow/underflow flag pulses from the counter.
- TSR flags are write-1-to-clear: a write to TSR with no pending events always reads back 8'h00.

Parameters:
- WAIT_CYCLES, 0: wait states inserted in the access phase before pready; legal range 0..3.
- TDR_RST, 8'h00: reset value of TDR.

Ports:
- pclk  in  1  system clock; all logic is rising-edge.
- preset  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  8  register address.
- pwdata  in  8  write data.
- prdata  out  8  read data; valid only while pready=1.
- pready  out  1  transfer complete (registered).
- pslverr  out  1  error response; valid only while pready=1.
- ovf_set  in  1  1-cycle overflow pulse from the counter.
- udf_set  in  1  1-cycle underflow pulse from the counter.
- tdr  out  8  timer load value.
- tcr  out  8  timer control (bit7 load, bit5 up/down, bit4 enable, bits1:0 clock select; bits 6,3,2 always 0).
- tsr  out  2  {udf, ovf} status flags.

Behaviour:
- Reset (preset=1 at an edge) sets:
  - state=IDLE, wait counter=0;
  - pready=0, pslverr=0, prdata=8'h00;
  - tdr=TDR_RST, tcr=8'h00, tsr=2'b00.
- Register map:
  - 0x00 TDR: R/W, full 8 bits.
  - 0x01 TCR: R/W; bits 6,3,2 are not stored and read 0.
  - 0x02 TSR: bit0 ovf, bit1 udf; bits 7:2 read 0; writing 1 to a bit clears it, writing 0 leaves it unchanged.
  - Any other address is an error.
- FSM states:
  - IDLE: psel=1 and penable=0 -> SETUP. psel=1 and penable=1 in IDLE is a protocol violation: ignore it, stay IDLE, pready stays 0.
  - SETUP: one cycle. Load wait counter with WAIT_CYCLES. If WAIT_CYCLES=0, register pready=1 for the next cycle. Go to ACCESS.
  - ACCESS: hold while the counter is nonzero, decrementing each cycle. Assert the pready register when the counter reaches 0.
- Completion and latency:
  - The transfer completes in the ACCESS cycle where pready=1 and psel=penable=1. That is WAIT_CYCLES+1 cycles after SETUP.
  - Next state after completion: SETUP if psel=1 and penable=0, otherwise IDLE.
  - pready returns to 0 in the cycle after completion.
  - Back-to-back transfers therefore take WAIT_CYCLES+2 cycles each.
- Writes:
  - Committed only at the completion edge.
  - Registers change one cycle after pready=1.
- Reads:
  - prdata is loaded with the register value, sampled at the last wait edge, so it is valid together with pready.
  - prdata is 8'h00 whenever pready=0.
- Error transfers (bad address):
  - pslverr=1 together with pready, same latency as a normal transfer.
  - No register changes; prdata=8'h00.
- Aborted transfers: if psel drops during ACCESS before completion, return to IDLE and perform no write.
- TSR update priority, per bit:
  - Hardware set beats the software clear in the same cycle, so the flag stays 1.
  - ovf_set and udf_set may be asserted together; both bits set.
  - A set while the flag is already 1 has no effect.
- TCR load bit (bit7) is plain storage; software clears it, the register block never clears it.
- Reset mid-transfer: abort, apply all reset values at that edge, no partial write. The master must restart the transfer.
- Unknown FSM encodings return to IDLE.

Test Plan:
- Reset: assert preset 2 cycles -> tdr=8'h00, tcr=8'h00, tsr=0, pready=0, pslverr=0, prdata=8'h00.
- TDR write 0xA5 then read, with WAIT_CYCLES=0 and again with WAIT_CYCLES=2:
  - read returns 0xA5;
  - pready rises exactly 1 (resp. 3) cycles after SETUP;
  - pslverr=0.
- TCR write 0xFF -> read 0xB3 (0xFF with reserved bits 6,3,2 cleared); tcr output=0xB3.
- TSR, three cases:
  - 10 random writes with no events -> every read returns 0x00;
  - pulse ovf_set -> read 0x01; write 0x01 -> read 0x00;
  - ovf_set in the same cycle as a W1C write -> read 0x01.
- Error: write 0x55 to 0x07 -> pslverr=1 with pready, all registers unchanged; read of 0x07 -> prdata=0x00, pslverr=1.
- Reset during ACCESS of a TDR write with WAIT_CYCLES=2 -> tdr stays 8'h00 and state=IDLE. A subsequent full transfer completes normally.

Source files
------------

// File: rtl/timer_apb_if.sv
// APB bus bundle between the CPU-side master and the timer register block.
interface timer_apb_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/timer_apb_regif.sv
// APB responder holding the timer TDR/TCR/TSR registers, with a fixed number
// of wait states per transfer and an error response for unmapped addresses.
module timer_apb_regif #(
    parameter int         WAIT_CYCLES = 0,
    parameter logic [7:0] TDR_RST     = 8'h00
) (
    input  logic             pclk,
    input  logic             preset,
    timer_apb_if.slave       apb,
    input  logic             ovf_set,
    input  logic             udf_set,
    output logic [7:0]       tdr,
    output logic [7:0]       tcr,
    output logic [1:0]       tsr
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    localparam logic [1:0] WAIT_LD  = 2'(WAIT_CYCLES);
    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h01;
    localparam logic [7:0] ADDR_TSR = 8'h02;
    localparam logic [7:0] TCR_MASK = 8'hB3;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pready_q, pready_d;
    logic       pslverr_q, pslverr_d;
    logic [7:0] prdata_q, prdata_d;
    logic [7:0] tdr_q, tdr_d;
    logic [7:0] tcr_q, tcr_d;
    logic [1:0] tsr_q, tsr_d;

    logic       addr_ok;
    logic       done;
    logic       wr_done;
    logic [7:0] rd_val;
    logic [7:0] rsp_data;
    logic [1:0] tsr_clr;

    always_comb begin
        addr_ok  = (apb.paddr <= ADDR_TSR);
        done     = (state_q == ACCESS) && pready_q && apb.psel && apb.penable;
        wr_done  = done && apb.pwrite && addr_ok;
        case (apb.paddr)
            ADDR_TDR: rd_val = tdr_q;
            ADDR_TCR: rd_val = tcr_q;
            ADDR_TSR: rd_val = {6'b0, tsr_q};
            default:  rd_val = 8'h00;
        endcase
        rsp_data = (addr_ok && !apb.pwrite) ? rd_val : 8'h00;
        tsr_clr  = (wr_done && apb.paddr == ADDR_TSR) ? apb.pwdata[1:0] : 2'b00;

        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = 8'h00;
        tdr_d     = tdr_q;
        tcr_d     = tcr_q;
        // Hardware set is OR-ed in after the clear so a same-cycle event wins.
        tsr_d     = (tsr_q & ~tsr_clr) | {udf_set, ovf_set};
        if (wr_done && apb.paddr == ADDR_TDR) tdr_d = apb.pwdata;
        if (wr_done && apb.paddr == ADDR_TCR) tcr_d = apb.pwdata & TCR_MASK;

        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) state_d = SETUP;
            end
            SETUP: begin
                cnt_d   = WAIT_LD;
                state_d = ACCESS;
                if (WAIT_CYCLES == 0) begin
                    pready_d  = 1'b1;
                    pslverr_d = !addr_ok;
                    prdata_d  = rsp_data;
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (done) begin
                    state_d = (apb.psel && !apb.penable) ? SETUP : IDLE;
                end else if (pready_q) begin
                    pready_d  = pready_q;
                    pslverr_d = pslverr_q;
                    prdata_d  = prdata_q;
                end else if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                    // Response is captured on the last wait edge.
                    if (cnt_q == 2'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = !addr_ok;
                        prdata_d  = rsp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 8'h00;
            tdr_q     <= TDR_RST;
            tcr_q     <= 8'h00;
            tsr_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            tdr_q     <= tdr_d;
            tcr_q     <= tcr_d;
            tsr_q     <= tsr_d;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign tdr         = tdr_q;
    assign tcr         = tcr_q;
    assign tsr         = tsr_q;
endmodule

// File: tb/tb_timer_apb_regif.sv
// Bench for timer_apb_regif: one instance with no wait states, one with two.
module tb_timer_apb_regif;
    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic preset;
    logic ovf_set, udf_set;
    logic chk_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    timer_apb_if bus0();
    timer_apb_if bus1();

    logic [7:0] tdr0, tcr0, tdr1, tcr1;
    logic [1:0] tsr0, tsr1;

    logic       m_psel[2], m_penable[2], m_pwrite[2];
    logic [7:0] m_paddr[2], m_pwdata[2];

    assign bus0.psel = m_psel[0];  assign bus0.penable = m_penable[0];
    assign bus0.pwrite = m_pwrite[0]; assign bus0.paddr = m_paddr[0];
    assign bus0.pwdata = m_pwdata[0];
    assign bus1.psel = m_psel[1];  assign bus1.penable = m_penable[1];
    assign bus1.pwrite = m_pwrite[1]; assign bus1.paddr = m_paddr[1];
    assign bus1.pwdata = m_pwdata[1];

    logic       o_pready[2], o_pslverr[2];
    logic [7:0] o_prdata[2], o_tdr[2], o_tcr[2];
    logic [1:0] o_tsr[2];
    assign o_pready[0] = bus0.pready;  assign o_pready[1] = bus1.pready;
    assign o_pslverr[0] = bus0.pslverr; assign o_pslverr[1] = bus1.pslverr;
    assign o_prdata[0] = bus0.prdata;  assign o_prdata[1] = bus1.prdata;
    assign o_tdr[0] = tdr0; assign o_tdr[1] = tdr1;
    assign o_tcr[0] = tcr0; assign o_tcr[1] = tcr1;
    assign o_tsr[0] = tsr0; assign o_tsr[1] = tsr1;

    timer_apb_regif #(.WAIT_CYCLES(0), .TDR_RST(8'h00)) u_dut0 (
        .pclk(pclk), .preset(preset), .apb(bus0), .ovf_set(ovf_set),
        .udf_set(udf_set), .tdr(tdr0), .tcr(tcr0), .tsr(tsr0));
    timer_apb_regif #(.WAIT_CYCLES(2), .TDR_RST(8'h00)) u_dut1 (
        .pclk(pclk), .preset(preset), .apb(bus1), .ovf_set(ovf_set),
        .udf_set(udf_set), .tdr(tdr1), .tcr(tcr1), .tsr(tsr1));

    // Register-file model: architectural values each instance must show.
    int         waitc[2] = '{0, 2};
    logic [7:0] tdr_m[2], tcr_m[2];
    logic [1:0] tsr_m[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            tdr_m[k] = 8'h00; tcr_m[k] = 8'h00; tsr_m[k] = 2'b00;
        end
    endtask

    function automatic logic [7:0] mread(input int s, input logic [7:0] a);
        case (a)
            8'h00:   return tdr_m[s];
            8'h01:   return tcr_m[s];
            8'h02:   return {6'b0, tsr_m[s]};
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge pclk) begin
        if (chk_en) begin
            for (int s = 0; s < 2; s++) begin
                chk("tdr_out", o_tdr[s], tdr_m[s]);
                chk("tcr_out", o_tcr[s], tcr_m[s]);
                chk("tsr_out", o_tsr[s], tsr_m[s]);
                if (!o_pready[s]) chk("prdata_idle", o_prdata[s], 8'h00);
            end
        end
    end

    task automatic xfer(input int s, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wd, input bit pulse,
                        output logic [7:0] rd, output bit err, output int lat);
        @(posedge pclk); #1;
        m_psel[s] = 1'b1; m_penable[s] = 1'b0; m_pwrite[s] = wr;
        m_paddr[s] = addr; m_pwdata[s] = wd;
        @(posedge pclk); #1;
        m_penable[s] = 1'b1;
        lat = 0;
        @(negedge pclk);
        while (!o_pready[s] && lat < 20) begin
            @(negedge pclk);
            lat++;
        end
        chk("pready_seen", o_pready[s], 1'b1);
        rd  = o_prdata[s];
        err = o_pslverr[s];
        if (pulse) ovf_set = 1'b1;
        @(posedge pclk); #1;
        m_psel[s] = 1'b0; m_penable[s] = 1'b0; ovf_set = 1'b0;
    endtask

    task automatic do_xfer(input int s, input bit wr, input logic [7:0] addr,
                           input logic [7:0] wd, input bit pulse,
                           output logic [7:0] rd, output bit err);
        logic [7:0] exp_rd;
        int lat;
        exp_rd = mread(s, addr);
        xfer(s, wr, addr, wd, pulse, rd, err, lat);
        chk("latency", lat, waitc[s] + 1);
        chk("pslverr", err, addr > 8'h02);
        if (!wr) chk("prdata", rd, exp_rd);
        if (wr) begin
            if (addr == 8'h00) tdr_m[s] = wd;
            if (addr == 8'h01) tcr_m[s] = wd & 8'hB3;
            if (addr == 8'h02) tsr_m[s] = tsr_m[s] & ~wd[1:0];
        end
        if (pulse) for (int k = 0; k < 2; k++) tsr_m[k] = tsr_m[k] | 2'b01;
    endtask

    task automatic pulse_evt(input logic ov, input logic ud);
        @(posedge pclk); #1;
        ovf_set = ov; udf_set = ud;
        @(posedge pclk); #1;
        ovf_set = 1'b0; udf_set = 1'b0;
        for (int k = 0; k < 2; k++) tsr_m[k] = tsr_m[k] | {ud, ov};
    endtask

    logic [7:0] rd;
    bit         err;

    initial begin
        preset = 1'b1; ovf_set = 1'b0; udf_set = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_psel[k] = 1'b0; m_penable[k] = 1'b0; m_pwrite[k] = 1'b0;
            m_paddr[k] = 8'h00; m_pwdata[k] = 8'h00;
        end
        repeat (2) @(posedge pclk);
        #1;
        preset = 1'b0;
        model_reset();
        for (int s = 0; s < 2; s++) begin
            chk("rst_tdr", o_tdr[s], 8'h00);
            chk("rst_tcr", o_tcr[s], 8'h00);
            chk("rst_tsr", o_tsr[s], 2'b00);
            chk("rst_pready", o_pready[s], 1'b0);
            chk("rst_pslverr", o_pslverr[s], 1'b0);
            chk("rst_prdata", o_prdata[s], 8'h00);
        end
        chk_en = 1'b1;

        // TDR write/read on both wait-state settings
        for (int s = 0; s < 2; s++) begin
            do_xfer(s, 1'b1, 8'h00, 8'hA5, 1'b0, rd, err);
            do_xfer(s, 1'b0, 8'h00, 8'h00, 1'b0, rd, err);
            chk("tdr_read_a5", rd, 8'hA5);
            chk("tdr_read_err", err, 1'b0);
        end

        // TCR reserved bits
        do_xfer(0, 1'b1, 8'h01, 8'hFF, 1'b0, rd, err);
        chk("tcr_out_b3", tcr0, 8'hB3);
        do_xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, rd, err);
        chk("tcr_read_b3", rd, 8'hB3);

        // TSR writes without events always read zero
        for (int i = 0; i < 10; i++) begin
            do_xfer(0, 1'b1, 8'h02, 8'($urandom), 1'b0, rd, err);
            do_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, err);
            chk("tsr_rand_zero", rd, 8'h00);
        end

        pulse_evt(1'b1, 1'b0);
        do_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, err);
        chk("tsr_ovf_set", rd, 8'h01);
        do_xfer(0, 1'b1, 8'h02, 8'h01, 1'b0, rd, err);
        do_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, err);
        chk("tsr_ovf_clr", rd, 8'h00);

        // Set coincident with the W1C completion edge keeps the flag
        pulse_evt(1'b1, 1'b0);
        do_xfer(0, 1'b1, 8'h02, 8'h01, 1'b1, rd, err);
        do_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, err);
        chk("tsr_set_beats_clr", rd, 8'h01);

        pulse_evt(1'b1, 1'b1);
        do_xfer(1, 1'b0, 8'h02, 8'h00, 1'b0, rd, err);
        chk("tsr_both_set", rd, 8'h03);
        do_xfer(1, 1'b1, 8'h02, 8'h03, 1'b0, rd, err);
        do_xfer(1, 1'b0, 8'h02, 8'h00, 1'b0, rd, err);
        chk("tsr_both_clr", rd, 8'h00);

        // Unmapped address
        for (int s = 0; s < 2; s++) begin
            do_xfer(s, 1'b1, 8'h07, 8'h55, 1'b0, rd, err);
            chk("err_wr_pslverr", err, 1'b1);
            do_xfer(s, 1'b0, 8'h07, 8'h00, 1'b0, rd, err);
            chk("err_rd_pslverr", err, 1'b1);
            chk("err_rd_prdata", rd, 8'h00);
        end
        chk("err_tdr_kept", tdr0, 8'hA5);

        // Reset in the middle of a wait-state access
        @(posedge pclk); #1;
        m_psel[1] = 1'b1; m_penable[1] = 1'b0; m_pwrite[1] = 1'b1;
        m_paddr[1] = 8'h00; m_pwdata[1] = 8'h77;
        @(posedge pclk); #1;
        m_penable[1] = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        model_reset();
        chk("rst_mid_tdr", tdr1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("rst_mid_no_pready", o_pready[1], 1'b0);
        end
        @(posedge pclk); #1;
        m_psel[1] = 1'b0; m_penable[1] = 1'b0;
        do_xfer(1, 1'b1, 8'h00, 8'h3C, 1'b0, rd, err);
        do_xfer(1, 1'b0, 8'h00, 8'h00, 1'b0, rd, err);
        chk("post_rst_read", rd, 8'h3C);

        repeat (2) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
